// File: rtl/tx_medida_serial.sv
// UART transmitter for the HC-SR04 distance: sends D2 D1 D0 SEPARADOR as ASCII, 8N1 by default.
// Define TX_PARIDADE_EN to send each character as 8E1 (even parity bit after data bit 7).
module tx_medida_serial #(
  parameter int         CLK_FREQ  = 50_000_000,
  parameter int         BAUD      = 115200,
  parameter logic [7:0] SEPARADOR = 8'h23
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       partida,
  input  logic [3:0] digito2,
  input  logic [3:0] digito1,
  input  logic [3:0] digito0,
  output logic       saida_serial,
  output logic       ocupado,
  output logic       pronto_tx,
  output logic [3:0] db_estado
);

  localparam int CICLOS_BIT = CLK_FREQ / BAUD;
  localparam int TW         = (CICLOS_BIT > 2) ? $clog2(CICLOS_BIT) : 1;
`ifdef TX_PARIDADE_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  typedef enum logic [3:0] {
    S_INICIAL   = 4'b0000,
    S_CARREGA   = 4'b0001,
    S_TRANSMITE = 4'b0010,
    S_PROXIMO   = 4'b0011,
    S_FINAL     = 4'b1111
  } estado_t;

  estado_t         r_estado;
  estado_t         w_prox_estado;
  logic [3:0]      w_db_estado;
  logic [TW-1:0]   r_tick;
  logic [3:0]      r_bit;
  logic [1:0]      r_idx;
  logic [3:0]      r_d2, r_d1, r_d0;
  logic [NB-1:0]   r_shift;
  logic            w_fim_bit;
  logic            w_ultimo_bit;
  logic [7:0]      w_char_prox;

  function automatic logic [7:0] ascii_de(input logic [3:0] d);
    return (d > 4'd9) ? 8'h3F : (8'h30 + {4'h0, d});
  endfunction

  // Shift order on the line is bit 0 first: start, data LSB..MSB, [parity], stop.
  function automatic logic [NB-1:0] quadro_de(input logic [7:0] c);
`ifdef TX_PARIDADE_EN
    return {1'b1, ^c, c, 1'b0};
`else
    return {1'b1, c, 1'b0};
`endif
  endfunction

  assign w_fim_bit    = (r_tick == TW'(CICLOS_BIT - 1));
  assign w_ultimo_bit = (r_bit == 4'(NB - 1));

  // Character that follows the one at r_idx; only indices 0..2 reach this path.
  always_comb begin
    w_char_prox = SEPARADOR;
    case (r_idx)
      2'd0:    w_char_prox = ascii_de(r_d1);
      2'd1:    w_char_prox = ascii_de(r_d0);
      default: w_char_prox = SEPARADOR;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_estado <= S_INICIAL;
    else       r_estado <= w_prox_estado;
  end

  always_comb begin
    w_prox_estado = r_estado;
    w_db_estado   = r_estado;
    case (r_estado)
      S_INICIAL:   if (partida) w_prox_estado = S_CARREGA;
      S_CARREGA:   w_prox_estado = S_TRANSMITE;
      S_TRANSMITE: if (w_fim_bit && w_ultimo_bit) w_prox_estado = S_PROXIMO;
      S_PROXIMO:   w_prox_estado = (r_idx == 2'd3) ? S_FINAL : S_TRANSMITE;
      S_FINAL:     w_prox_estado = S_INICIAL;
      default: begin
        w_prox_estado = S_INICIAL;
        w_db_estado   = 4'b1110;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_tick  <= '0;
      r_bit   <= '0;
      r_idx   <= '0;
      r_d2    <= '0;
      r_d1    <= '0;
      r_d0    <= '0;
      r_shift <= '1;
    end else begin
      case (r_estado)
        S_CARREGA: begin
          r_d2    <= digito2;
          r_d1    <= digito1;
          r_d0    <= digito0;
          r_idx   <= 2'd0;
          r_shift <= quadro_de(ascii_de(digito2));
          r_tick  <= '0;
          r_bit   <= '0;
        end
        S_TRANSMITE: begin
          if (w_fim_bit) begin
            r_tick <= '0;
            if (!w_ultimo_bit) begin
              r_bit   <= r_bit + 4'd1;
              r_shift <= {1'b1, r_shift[NB-1:1]};
            end
          end else begin
            r_tick <= r_tick + TW'(1);
          end
        end
        S_PROXIMO: begin
          if (r_idx != 2'd3) begin
            r_idx   <= r_idx + 2'd1;
            r_shift <= quadro_de(w_char_prox);
            r_tick  <= '0;
            r_bit   <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  // Line only follows the shift register while transmitting, so reset forces it high at once.
  assign saida_serial = (r_estado == S_TRANSMITE) ? r_shift[0] : 1'b1;
  assign ocupado      = (r_estado == S_CARREGA) || (r_estado == S_TRANSMITE) ||
                        (r_estado == S_PROXIMO) || (r_estado == S_FINAL);
  assign pronto_tx    = (r_estado == S_FINAL);
  assign db_estado    = w_db_estado;

endmodule

// File: tb/tb_tx_medida_serial.sv
// Directed-sequence bench for tx_medida_serial with a cycle-level expected line waveform built from the UART frame rules.
module tb_tx_medida_serial;

  localparam int C = 10;
`ifdef TX_PARIDADE_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int CHAR_LEN  = NB * C + 1;
  localparam int FRAME_LEN = 4 * CHAR_LEN;

  logic       clock = 1'b0;
  logic       reset;
  logic       partida;
  logic [3:0] digito2, digito1, digito0;
  logic       saida_serial, ocupado, pronto_tx;
  logic [3:0] db_estado;

  int         n_tests = 0;
  int         n_fail  = 0;
  logic [7:0] exp_q[$];

  tx_medida_serial #(.CLK_FREQ(1000), .BAUD(100), .SEPARADOR(8'h23)) dut (
    .clock(clock), .reset(reset), .partida(partida),
    .digito2(digito2), .digito1(digito1), .digito0(digito0),
    .saida_serial(saida_serial), .ocupado(ocupado), .pronto_tx(pronto_tx),
    .db_estado(db_estado)
  );

  always #5 clock = ~clock;

  function automatic logic [7:0] ascii_of(input int d);
    return (d > 9) ? 8'h3F : 8'(48 + d);
  endfunction

  // Expected line level for bit slot b of a character (0 = start).
  function automatic logic exp_bit(input logic [7:0] ch, input int b);
    if (b == 0) return 1'b0;
    if (b <= 8) return ch[b-1];
    if (NB == 11 && b == 9) return ^ch;
    return 1'b1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_expected(input int a, input int b, input int c);
    exp_q.push_back(ascii_of(a));
    exp_q.push_back(ascii_of(b));
    exp_q.push_back(ascii_of(c));
    exp_q.push_back(8'h23);
  endtask

  // Call right after the negedge where partida was raised.
  task automatic check_frame(input bit release_partida, input bit disturb);
    logic [7:0] ch, rx;
    int bad_line, bad_busy, bad_pr, ci, pos, b;
    bad_line = 0; bad_busy = 0; bad_pr = 0; ch = 8'h00; rx = 8'h00;
    @(negedge clock);
    if (release_partida) partida = 1'b0;
    chk("carrega_db", 32'(db_estado), 32'd1);
    chk("carrega_busy", 32'(ocupado), 32'd1);
    chk("carrega_line", 32'(saida_serial), 32'd1);
    for (int k = 0; k < FRAME_LEN; k++) begin
      @(negedge clock);
      ci  = k / CHAR_LEN;
      pos = k % CHAR_LEN;
      b   = pos / C;
      if (pos == 0) ch = exp_q[ci];
      if (saida_serial !== ((pos == NB * C) ? 1'b1 : exp_bit(ch, b))) bad_line++;
      if (ocupado !== 1'b1) bad_busy++;
      if (pronto_tx !== 1'b0) bad_pr++;
      if (pos < NB * C && pos % C == C / 2 && b >= 1 && b <= 8) rx[b-1] = saida_serial;
      if (pos == NB * C) chk($sformatf("char%0d", ci), 32'(rx), 32'(ch));
      if (disturb) begin
        if (k == 37) partida = 1'b1;
        if (k == 38) partida = 1'b0;
        if (k == 120) digito0 = ~digito0;
        if (k == 250) digito2 = ~digito2;
      end
    end
    chk("line_waveform_errors", 32'(bad_line), 32'd0);
    chk("busy_during_frame_errors", 32'(bad_busy), 32'd0);
    chk("pronto_early_errors", 32'(bad_pr), 32'd0);
    @(negedge clock);
    chk("final_pronto", 32'(pronto_tx), 32'd1);
    chk("final_db", 32'(db_estado), 32'hF);
    chk("final_line", 32'(saida_serial), 32'd1);
    @(negedge clock);
    chk("idle_pronto", 32'(pronto_tx), 32'd0);
    chk("idle_busy", 32'(ocupado), 32'd0);
    chk("idle_db", 32'(db_estado), 32'd0);
    repeat (4) void'(exp_q.pop_front());
  endtask

  task automatic start_frame(input int a, input int b, input int c);
    @(negedge clock);
    digito2 = 4'(a); digito1 = 4'(b); digito0 = 4'(c);
    partida = 1'b1;
    push_expected(a, b, c);
  endtask

  initial begin
    reset = 1'b1; partida = 1'b0;
    digito2 = 4'd0; digito1 = 4'd0; digito0 = 4'd0;
    #1;
    chk("reset_line", 32'(saida_serial), 32'd1);
    chk("reset_busy", 32'(ocupado), 32'd0);
    chk("reset_pronto", 32'(pronto_tx), 32'd0);
    chk("reset_db", 32'(db_estado), 32'd0);
    @(negedge clock); reset = 1'b0;
    repeat (3) @(negedge clock);

    // Nominal digits 3,7,5.
    start_frame(3, 7, 5);
    check_frame(1'b1, 1'b0);

    // Non-BCD tens digit maps to '?'.
    start_frame(3, 12, 5);
    check_frame(1'b1, 1'b0);

    // Mid-frame partida pulse and digit changes must not alter the frame.
    start_frame(int'($urandom_range(0, 9)), int'($urandom_range(0, 9)), int'($urandom_range(0, 9)));
    check_frame(1'b1, 1'b1);

    // Reset during data bits of the third character aborts the frame.
    @(negedge clock);
    digito2 = 4'd1; digito1 = 4'd2; digito0 = 4'd9; partida = 1'b1;
    @(negedge clock); partida = 1'b0;
    repeat (2 * CHAR_LEN + 3 * C + 5) @(negedge clock);
    reset = 1'b1;
    #1;
    chk("abort_line", 32'(saida_serial), 32'd1);
    chk("abort_busy", 32'(ocupado), 32'd0);
    chk("abort_db", 32'(db_estado), 32'd0);
    chk("abort_pronto", 32'(pronto_tx), 32'd0);
    @(negedge clock); reset = 1'b0;
    @(negedge clock);
    start_frame(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
    check_frame(1'b1, 1'b0);

    // partida held high: back-to-back frames with one idle cycle between.
    start_frame(8, 0, 4);
    push_expected(8, 0, 4);
    check_frame(1'b0, 1'b0);
    check_frame(1'b0, 1'b0);
    partida = 1'b0;
    repeat (3) @(negedge clock);
    chk("after_hold_busy", 32'(ocupado), 32'd0);

    // Random digits across the full nibble range.
    for (int i = 0; i < 3; i++) begin
      start_frame(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
      check_frame(1'b1, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
